ysyx_22050019_axi_rd_arbiter: RTL and testbench
===============================================

# ysyx_22050019_axi_rd_arbiter

Read-channel arbiter that shares one downstream AXI-lite-style read port (AR + R, single beat) between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the pipeline front/back ends and the memory/bus bridge. It grants one outstanding read at a time, with fixed LSU priority and a starvation guard for IFU, and routes the response back to the granted requester.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, read data width
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU waits; range 1–15

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- ifu_arvalid / ifu_arready  in / out  1  IFU address handshake
- ifu_araddr  in  ADDR_W  IFU address
- ifu_arsize  in  3  IFU size (IFU ties to 3'b011)
- ifu_rvalid / ifu_rready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  response data
- ifu_rresp  out  2  response status
- lsu_arvalid, lsu_arready, lsu_araddr, lsu_arsize, lsu_rvalid, lsu_rready, lsu_rdata, lsu_rresp: same as IFU set, for LSU
- m_axi_arvalid  out  1  downstream address valid
- m_axi_arready  in  1  downstream address ready
- m_axi_araddr  out  ADDR_W  downstream address
- m_axi_arsize  out  3  downstream size
- m_axi_rvalid  in  1  downstream response valid
- m_axi_rready  out  1  downstream response ready
- m_axi_rdata  in  DATA_W  downstream data
- m_axi_rresp  in  2  downstream status
- arb_grant  out  2  one-hot current owner {lsu, ifu}; 2'b00 when idle

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any *_arvalid, choose winner, register grant, go to ADDR next cycle. No request: stay.
- Winner rule: LSU wins if requesting, unless IFU is requesting and streak == MAX_LSU_STREAK, then IFU wins. Single requester always wins.
- Streak counter (4 bits): +1 on LSU grant while ifu_arvalid high; cleared on IFU grant or on LSU grant with ifu_arvalid low; saturates at MAX_LSU_STREAK.
- ADDR: m_axi_arvalid = 1; m_axi_araddr/arsize muxed combinationally from granted requester. Granted *_arready = m_axi_arready; other requester's arready = 0. On m_axi_arvalid & m_axi_arready go to DATA.
- DATA: m_axi_rready = granted *_rready; granted *_rvalid = m_axi_rvalid; other rvalid = 0. rdata/rresp broadcast to both requesters. On m_axi_rvalid & m_axi_rready go to IDLE, clear grant.
- Requesters must hold arvalid/araddr/arsize stable until arready; dropping arvalid in ADDR is a protocol error, grant is kept, downstream still issues.
- rresp passed unmodified; errors are the requester's concern.

## Timing
- Reset (rst_n == 0 at clk edge): state IDLE, grant 00, streak 0. All outputs 0: m_axi_arvalid, m_axi_rready, *_arready, *_rvalid, arb_grant. Data outputs follow muxes (don't-care when idle, drive 0 when grant 00).
- Reset mid-transaction: abandon immediately; in-flight downstream response is not tracked (bus bridge resets in the same cycle).
- Latency: request visible at edge T → m_axi_arvalid high in cycle T+1. Earliest requester arready in T+1 (if m_axi_arready high). Response forwarded combinationally, zero added cycles.
- Back-to-back: one IDLE cycle between response handshake and next ADDR; minimum 3 cycles per transaction.
- Simultaneous requests in IDLE: resolved by winner rule in that cycle; loser's arvalid held and considered at next IDLE.
- No combinational path from *_arvalid to *_arready.

## Structure
- Shared package: state encoding (IDLE/ADDR/DATA), grant encodings GNT_NONE/GNT_IFU/GNT_LSU.
- One sub-module natural: ysyx_22050019_arb_prio (winner select + streak counter), FSM and muxing in top.

## Test plan
- IFU only, araddr 0x8000_0000, m_axi_arready=1, rvalid 2 cycles later with rdata 0x0000_0013_0000_0093 → m_axi_araddr 0x8000_0000 in T+1, ifu_rvalid with that data, lsu_rvalid stays 0, arb_grant 01→00.
- IFU and LSU both request at T (LSU 0x8000_1000) → LSU granted first (arb_grant 10), IFU served next, 1-cycle IDLE gap between.
- LSU requests continuously, IFU held high, MAX_LSU_STREAK=4 → grants LSU,LSU,LSU,LSU,IFU,LSU…
- m_axi_arready low 5 cycles in ADDR → m_axi_arvalid and address stable 5 cycles, requester arready 0 until handshake.
- lsu_rready low 3 cycles while m_axi_rvalid high, rresp 2'b10 → m_axi_rready 0 for those cycles; lsu_rresp=2'b10 on handshake.
- rst_n low during DATA → next cycle all valid/ready outputs 0, arb_grant 00, new IFU request served normally.

Source files
------------

// File: rtl/ysyx_22050019_axi_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU read-channel arbiter: FSM states and
// the one-hot grant encodings {lsu, ifu}.
package ysyx_22050019_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IFU  = 2'b01;
    localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_22050019_arb_prio.sv
// Winner selection for the read arbiter: LSU has fixed priority, but after
// MAX_LSU_STREAK back-to-back LSU wins with IFU waiting, IFU gets one turn.
module ysyx_22050019_arb_prio
    import ysyx_22050019_axi_rd_arbiter_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ifu_req,
    input  logic       i_lsu_req,
    input  logic       i_take,
    output logic [1:0] o_winner
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

    logic [3:0] r_streak;
    logic       w_ifu_due;

    assign w_ifu_due = i_ifu_req && (r_streak == STREAK_MAX);

    always_comb begin
        o_winner = GNT_NONE;
        if (i_lsu_req && !w_ifu_due) begin
            o_winner = GNT_LSU;
        end else if (i_ifu_req) begin
            o_winner = GNT_IFU;
        end
    end

    // Streak only grows while IFU is actually being passed over.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_streak <= '0;
        end else if (i_take) begin
            if ((o_winner == GNT_LSU) && i_ifu_req) begin
                if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Shares one single-beat AXI-lite read port between IFU and LSU, one
// outstanding read at a time; the response is routed to the granted side.
module ysyx_22050019_axi_rd_arbiter
    import ysyx_22050019_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ifu_arvalid,
    output logic              o_ifu_arready,
    input  logic [ADDR_W-1:0] i_ifu_araddr,
    input  logic [2:0]        i_ifu_arsize,
    output logic              o_ifu_rvalid,
    input  logic              i_ifu_rready,
    output logic [DATA_W-1:0] o_ifu_rdata,
    output logic [1:0]        o_ifu_rresp,
    input  logic              i_lsu_arvalid,
    output logic              o_lsu_arready,
    input  logic [ADDR_W-1:0] i_lsu_araddr,
    input  logic [2:0]        i_lsu_arsize,
    output logic              o_lsu_rvalid,
    input  logic              i_lsu_rready,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic [1:0]        o_lsu_rresp,
    output logic              o_m_axi_arvalid,
    input  logic              i_m_axi_arready,
    output logic [ADDR_W-1:0] o_m_axi_araddr,
    output logic [2:0]        o_m_axi_arsize,
    input  logic              i_m_axi_rvalid,
    output logic              o_m_axi_rready,
    input  logic [DATA_W-1:0] i_m_axi_rdata,
    input  logic [1:0]        i_m_axi_rresp,
    output logic [1:0]        o_arb_grant
);

    arb_state_t r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt, w_winner;
    logic       w_take, w_in_addr, w_in_data, w_is_ifu, w_is_lsu;

    assign w_take    = (r_state == ST_IDLE) && (i_ifu_arvalid || i_lsu_arvalid);
    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_is_ifu  = (r_grant == GNT_IFU);
    assign w_is_lsu  = (r_grant == GNT_LSU);

    ysyx_22050019_arb_prio #(
        .MAX_LSU_STREAK(MAX_LSU_STREAK)
    ) u_prio (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_ifu_req(i_ifu_arvalid),
        .i_lsu_req(i_lsu_arvalid),
        .i_take   (w_take),
        .o_winner (w_winner)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_ADDR;
                    w_grant_nxt = w_winner;
                end
            end
            ST_ADDR: begin
                if (i_m_axi_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_m_axi_rvalid && o_m_axi_rready) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = GNT_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = GNT_NONE;
            end
        endcase
    end

    // Address side is muxed from the registered grant, so arvalid never
    // reaches arready combinationally.
    always_comb begin
        o_m_axi_arvalid = w_in_addr;
        o_m_axi_araddr  = '0;
        o_m_axi_arsize  = '0;
        if (w_is_lsu) begin
            o_m_axi_araddr = i_lsu_araddr;
            o_m_axi_arsize = i_lsu_arsize;
        end else if (w_is_ifu) begin
            o_m_axi_araddr = i_ifu_araddr;
            o_m_axi_arsize = i_ifu_arsize;
        end
        o_ifu_arready  = w_in_addr && w_is_ifu && i_m_axi_arready;
        o_lsu_arready  = w_in_addr && w_is_lsu && i_m_axi_arready;
        o_m_axi_rready = w_in_data && ((w_is_ifu && i_ifu_rready) || (w_is_lsu && i_lsu_rready));
        o_ifu_rvalid   = w_in_data && w_is_ifu && i_m_axi_rvalid;
        o_lsu_rvalid   = w_in_data && w_is_lsu && i_m_axi_rvalid;
        o_ifu_rdata    = i_m_axi_rdata;
        o_ifu_rresp    = i_m_axi_rresp;
        o_lsu_rdata    = i_m_axi_rdata;
        o_lsu_rresp    = i_m_axi_rresp;
        o_arb_grant    = r_grant;
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Self-checking bench for the IFU/LSU read arbiter: transaction-level model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ysyx_22050019_axi_rd_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        ifuArvalid, ifuArready, ifuRvalid, ifuRready;
    logic [63:0] ifuAraddr, ifuRdata;
    logic [2:0]  ifuArsize;
    logic [1:0]  ifuRresp;
    logic        lsuArvalid, lsuArready, lsuRvalid, lsuRready;
    logic [63:0] lsuAraddr, lsuRdata;
    logic [2:0]  lsuArsize;
    logic [1:0]  lsuRresp;
    logic        mArvalid, mArready, mRvalid, mRready;
    logic [63:0] mAraddr, mRdata;
    logic [2:0]  mArsize;
    logic [1:0]  mRresp;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;
    bit modelOn = 1'b0;

    // Model: who owns the port, whether its address was already accepted,
    // and how many LSU wins in a row IFU has had to sit through.
    int mOwner  = 0;
    bit mIssued = 1'b0;
    int mStreak = 0;

    logic [1:0] grantLog[$];
    int         grantCyc[$];
    logic [1:0] prevGrant = 2'b00;
    int         cycleCnt  = 0;

    int  ifuReqPct, lsuReqPct, arreadyPct, rvalidPct, rreadyPct, rstPermille;
    bit  dsPending;

    ysyx_22050019_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LSU_STREAK(MAX)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_ifu_arvalid(ifuArvalid), .o_ifu_arready(ifuArready), .i_ifu_araddr(ifuAraddr),
        .i_ifu_arsize(ifuArsize), .o_ifu_rvalid(ifuRvalid), .i_ifu_rready(ifuRready),
        .o_ifu_rdata(ifuRdata), .o_ifu_rresp(ifuRresp),
        .i_lsu_arvalid(lsuArvalid), .o_lsu_arready(lsuArready), .i_lsu_araddr(lsuAraddr),
        .i_lsu_arsize(lsuArsize), .o_lsu_rvalid(lsuRvalid), .i_lsu_rready(lsuRready),
        .o_lsu_rdata(lsuRdata), .o_lsu_rresp(lsuRresp),
        .o_m_axi_arvalid(mArvalid), .i_m_axi_arready(mArready), .o_m_axi_araddr(mAraddr),
        .o_m_axi_arsize(mArsize), .i_m_axi_rvalid(mRvalid), .o_m_axi_rready(mRready),
        .i_m_axi_rdata(mRdata), .i_m_axi_rresp(mRresp),
        .o_arb_grant(grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model, then advance the model using
    // the inputs that will be sampled at the coming rising edge.
    always @(negedge clk) begin
        if (modelOn) begin : cmp
            logic [1:0] expGrant;
            bit inAddr, inData, ownRready;
            expGrant  = (mOwner == 1) ? 2'b01 : (mOwner == 2) ? 2'b10 : 2'b00;
            inAddr    = (mOwner != 0) && !mIssued;
            inData    = (mOwner != 0) && mIssued;
            ownRready = (mOwner == 1) ? ifuRready : lsuRready;
            checkOutput("grant", 64'(grant), 64'(expGrant));
            checkOutput("m_arvalid", 64'(mArvalid), 64'(inAddr));
            if (inAddr) begin
                checkOutput("m_araddr", mAraddr, (mOwner == 2) ? lsuAraddr : ifuAraddr);
                checkOutput("m_arsize", 64'(mArsize), 64'((mOwner == 2) ? lsuArsize : ifuArsize));
            end
            checkOutput("ifu_arready", 64'(ifuArready), 64'(inAddr && mOwner == 1 && mArready));
            checkOutput("lsu_arready", 64'(lsuArready), 64'(inAddr && mOwner == 2 && mArready));
            checkOutput("m_rready", 64'(mRready), 64'(inData && ownRready));
            checkOutput("ifu_rvalid", 64'(ifuRvalid), 64'(inData && mOwner == 1 && mRvalid));
            checkOutput("lsu_rvalid", 64'(lsuRvalid), 64'(inData && mOwner == 2 && mRvalid));
            if (inData) begin
                checkOutput("ifu_rdata", ifuRdata, mRdata);
                checkOutput("lsu_rdata", lsuRdata, mRdata);
                checkOutput("ifu_rresp", 64'(ifuRresp), 64'(mRresp));
                checkOutput("lsu_rresp", 64'(lsuRresp), 64'(mRresp));
            end
            if (!rstN) begin
                mOwner  <= 0;
                mIssued <= 1'b0;
                mStreak <= 0;
            end else if (mOwner == 0) begin
                if (lsuArvalid && !(ifuArvalid && mStreak == MAX)) begin
                    mOwner  <= 2;
                    mStreak <= ifuArvalid ? ((mStreak < MAX) ? mStreak + 1 : MAX) : 0;
                end else if (ifuArvalid) begin
                    mOwner  <= 1;
                    mStreak <= 0;
                end
            end else if (!mIssued) begin
                if (mArready) mIssued <= 1'b1;
            end else if (mRvalid && ownRready) begin
                mOwner  <= 0;
                mIssued <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            if (grant != 2'b00 && prevGrant == 2'b00) begin
                grantLog.push_back(grant);
                grantCyc.push_back(cycleCnt);
            end
            prevGrant <= grant;
        end
    end

    // Behaves like both requesters and the downstream bridge, honouring the
    // hold-until-handshake rules, with the configured percentages steering traffic.
    task automatic applyStimulus(input int n);
        bit hsIfu, hsLsu, hsAr, hsR;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hsIfu = ifuArvalid && ifuArready;
            hsLsu = lsuArvalid && lsuArready;
            hsAr  = mArvalid && mArready;
            hsR   = mRvalid && mRready;
            tick();
            if (rstPermille > 0 && int'($urandom_range(0, 999)) < rstPermille) begin
                rstN = 1'b0; ifuArvalid = 1'b0; lsuArvalid = 1'b0;
                mRvalid = 1'b0; mArready = 1'b0; dsPending = 1'b0;
            end else begin
                rstN = 1'b1;
                if (hsIfu) ifuArvalid = 1'b0;
                if (hsLsu) lsuArvalid = 1'b0;
                if (!ifuArvalid && roll(ifuReqPct)) begin
                    ifuArvalid = 1'b1; ifuAraddr = {$urandom, $urandom}; ifuArsize = 3'b011;
                end
                if (!lsuArvalid && roll(lsuReqPct)) begin
                    lsuArvalid = 1'b1; lsuAraddr = {$urandom, $urandom}; lsuArsize = 3'($urandom_range(0, 7));
                end
                if (hsAr) dsPending = 1'b1;
                if (hsR) begin
                    mRvalid = 1'b0; dsPending = 1'b0;
                end
                if (dsPending && !mRvalid && roll(rvalidPct)) begin
                    mRvalid = 1'b1; mRdata = {$urandom, $urandom}; mRresp = 2'($urandom_range(0, 3));
                end
                mArready  = roll(arreadyPct);
                ifuRready = roll(rreadyPct);
                lsuRready = roll(rreadyPct);
            end
        end
    endtask

    task automatic setTraffic(input int iq, input int lq, input int ar, input int rv, input int rr, input int rs);
        ifuReqPct = iq; lsuReqPct = lq; arreadyPct = ar; rvalidPct = rv; rreadyPct = rr; rstPermille = rs;
    endtask

    task automatic doReset();
        ifuArvalid = 1'b0; lsuArvalid = 1'b0; mRvalid = 1'b0; mArready = 1'b0;
        ifuRready = 1'b0; lsuRready = 1'b0; dsPending = 1'b0;
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    initial begin
        logic [1:0] expSeq[6];
        expSeq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        ifuAraddr = '0; ifuArsize = 3'b011; lsuAraddr = '0; lsuArsize = 3'b011;
        mRdata = '0; mRresp = 2'b00;
        setTraffic(0, 0, 100, 100, 100, 0);
        ifuArvalid = 1'b0; lsuArvalid = 1'b0; mRvalid = 1'b0; mArready = 1'b0;
        ifuRready = 1'b0; lsuRready = 1'b0; dsPending = 1'b0;
        rstN = 1'b0;
        tick();
        modelOn = 1'b1;
        tick();
        checkOutput("rst_grant", 64'(grant), 64'(2'b00));
        checkOutput("rst_m_arvalid", 64'(mArvalid), 64'(1'b0));
        checkOutput("rst_m_rready", 64'(mRready), 64'(1'b0));
        rstN = 1'b1;

        // IFU alone, response two cycles after the address handshake.
        ifuArvalid = 1'b1; ifuAraddr = 64'h8000_0000; ifuArsize = 3'b011; mArready = 1'b1; ifuRready = 1'b1;
        tick();
        checkOutput("t1_araddr", mAraddr, 64'h8000_0000);
        checkOutput("t1_grant", 64'(grant), 64'(2'b01));
        checkOutput("t1_ifu_arready", 64'(ifuArready), 64'(1'b1));
        tick();
        ifuArvalid = 1'b0; mArready = 1'b0;
        tick();
        mRvalid = 1'b1; mRdata = 64'h0000_0013_0000_0093; mRresp = 2'b00;
        #1;
        checkOutput("t1_ifu_rvalid", 64'(ifuRvalid), 64'(1'b1));
        checkOutput("t1_ifu_rdata", ifuRdata, 64'h0000_0013_0000_0093);
        checkOutput("t1_lsu_rvalid", 64'(lsuRvalid), 64'(1'b0));
        tick();
        mRvalid = 1'b0;
        #1;
        checkOutput("t1_grant_idle", 64'(grant), 64'(2'b00));

        // Simultaneous requests: LSU first, IFU after exactly one idle cycle.
        grantLog.delete(); grantCyc.delete();
        ifuArvalid = 1'b1; ifuAraddr = 64'h8000_0004;
        lsuArvalid = 1'b1; lsuAraddr = 64'h8000_1000; lsuArsize = 3'b011;
        setTraffic(0, 0, 100, 100, 100, 0);
        applyStimulus(14);
        checkOutput("t2_count", 64'(grantLog.size()), 64'd2);
        if (grantLog.size() >= 2) begin
            checkOutput("t2_first", 64'(grantLog[0]), 64'(2'b10));
            checkOutput("t2_second", 64'(grantLog[1]), 64'(2'b01));
            checkOutput("t2_spacing", 64'(grantCyc[1] - grantCyc[0]), 64'd3);
        end

        // Continuous LSU with IFU waiting: IFU gets in after four LSU wins.
        doReset();
        grantLog.delete(); grantCyc.delete();
        ifuArvalid = 1'b1; ifuAraddr = 64'h8000_0100;
        lsuArvalid = 1'b1; lsuAraddr = 64'h8000_2000;
        setTraffic(100, 100, 100, 100, 100, 0);
        applyStimulus(30);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t3_seq%0d", i), 64'((i < grantLog.size()) ? grantLog[i] : 2'b11), 64'(expSeq[i]));
        end
        setTraffic(0, 0, 100, 100, 100, 0);
        applyStimulus(25);
        mArready = 1'b0; mRvalid = 1'b0; dsPending = 1'b0; ifuRready = 1'b0; lsuRready = 1'b0;
        checkOutput("t3_drained", 64'(grant), 64'(2'b00));

        // Downstream holds off the address for five cycles, then LSU stalls the response.
        lsuArvalid = 1'b1; lsuAraddr = 64'h8000_3008; lsuArsize = 3'b010;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_arvalid", 64'(mArvalid), 64'(1'b1));
            checkOutput("t4_araddr", mAraddr, 64'h8000_3008);
            checkOutput("t4_lsu_arready", 64'(lsuArready), 64'(1'b0));
            tick();
        end
        mArready = 1'b1;
        #1;
        checkOutput("t4_lsu_arready_hs", 64'(lsuArready), 64'(1'b1));
        tick();
        lsuArvalid = 1'b0; mArready = 1'b0;
        mRvalid = 1'b1; mRresp = 2'b10; mRdata = 64'h1234_5678_9abc_def0; lsuRready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t5_m_rready_low", 64'(mRready), 64'(1'b0));
            tick();
        end
        lsuRready = 1'b1;
        #1;
        checkOutput("t5_m_rready_hs", 64'(mRready), 64'(1'b1));
        checkOutput("t5_lsu_rresp", 64'(lsuRresp), 64'(2'b10));
        tick();
        mRvalid = 1'b0; lsuRready = 1'b0;

        // Reset while in the data phase, then a fresh IFU read.
        ifuArvalid = 1'b1; ifuAraddr = 64'h8000_0040; mArready = 1'b1;
        tick();
        tick();
        ifuArvalid = 1'b0; mArready = 1'b0; mRvalid = 1'b1; ifuRready = 1'b0;
        rstN = 1'b0;
        tick();
        checkOutput("t6_grant", 64'(grant), 64'(2'b00));
        checkOutput("t6_m_arvalid", 64'(mArvalid), 64'(1'b0));
        checkOutput("t6_m_rready", 64'(mRready), 64'(1'b0));
        checkOutput("t6_ifu_rvalid", 64'(ifuRvalid), 64'(1'b0));
        mRvalid = 1'b0; rstN = 1'b1;
        ifuArvalid = 1'b1; ifuAraddr = 64'h8000_0080; mArready = 1'b1;
        tick();
        checkOutput("t6_regrant", 64'(grant), 64'(2'b01));
        checkOutput("t6_araddr", mAraddr, 64'h8000_0080);
        tick();
        ifuArvalid = 1'b0; mArready = 1'b0; mRvalid = 1'b1; mRdata = 64'hdead_beef_0000_0001; ifuRready = 1'b1;
        #1;
        checkOutput("t6_ifu_rvalid_new", 64'(ifuRvalid), 64'(1'b1));
        tick();
        mRvalid = 1'b0; ifuRready = 1'b0;

        // Random traffic with occasional resets.
        setTraffic(40, 45, 60, 50, 70, 5);
        applyStimulus(3000);
        setTraffic(0, 0, 100, 100, 100, 0);
        applyStimulus(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
